rv32i_inst_decoder: RTL and testbench

Registered RV32I instruction decode stage sitting between program-memory fetch and the register file / ALU in `core`. It is the decode counterpart of the `encodeAddi`/`encodeAdd` style encoders used to build program images. It accepts one 32-bit instruction per cycle over a valid/ready handshake and splits it into register indices, a sign-extended immediate, an ALU operation code and control flags. Outputs are buffered so that downstream back-pressure never drops or duplicates an instruction.

---
 rtl/rv32i_inst_decoder_if.sv | 32 +++
 rtl/rv32i_inst_decoder.sv | 176 +++++++++++++++++
 tb/tb_rv32i_inst_decoder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_inst_decoder_if.sv
// rtl/rv32i_inst_decoder_if.sv - fetch-side and consumer-side handshake bundle of the RV32I decoder
interface rv32i_inst_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [31:0] out_imm;
    logic [3:0]  out_alu_op;
    logic        out_is_imm;
    logic        out_reg_write;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_imm, out_alu_op, out_is_imm, out_reg_write, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_imm, out_alu_op, out_is_imm, out_reg_write, out_illegal
    );
endinterface

// File: rtl/rv32i_inst_decoder.sv
// rtl/rv32i_inst_decoder.sv - registered RV32I decode stage with main + skid output buffering
module rv32i_inst_decoder (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    rv32i_inst_decoder_if.slave     bus,
    output logic [31:0]             decoded_count
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        is_imm;
        logic        reg_write;
        logic        illegal;
    } bundle_t;

    // alt selects SUB/SRA; the caller decides when funct7 is allowed to mean that
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic bundle_t decode(input logic [31:0] i, input logic [31:0] pc);
        bundle_t    b;
        logic [6:0] f7;
        f7          = i[31:25];
        b.pc        = pc;
        b.opcode    = i[6:0];
        b.rd        = i[11:7];
        b.rs1       = i[19:15];
        b.rs2       = i[24:20];
        b.funct3    = i[14:12];
        b.imm       = '0;
        b.alu_op    = ALU_ADD;
        b.is_imm    = 1'b0;
        b.reg_write = 1'b1;
        b.illegal   = 1'b0;
        case (i[6:0])
            OPC_LUI: begin
                b.imm    = {i[31:12], 12'b0};
                b.alu_op = ALU_PASS_B;
                b.is_imm = 1'b1;
            end
            OPC_AUIPC: begin
                b.imm    = {i[31:12], 12'b0};
                b.is_imm = 1'b1;
            end
            OPC_JAL:  b.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            OPC_JALR, OPC_LOAD: begin
                b.imm    = {{20{i[31]}}, i[31:20]};
                b.is_imm = 1'b1;
            end
            OPC_BRANCH: begin
                b.imm       = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                b.alu_op    = ALU_SUB;
                b.reg_write = 1'b0;
            end
            OPC_STORE: begin
                b.imm       = {{20{i[31]}}, i[31:25], i[11:7]};
                b.is_imm    = 1'b1;
                b.reg_write = 1'b0;
            end
            OPC_OP_IMM: begin
                b.imm     = {{20{i[31]}}, i[31:20]};
                b.is_imm  = 1'b1;
                b.alu_op  = alu_from_funct3(i[14:12], (i[14:12] == 3'b101) && (f7 == F7_ALT));
                b.illegal = ((i[14:12] == 3'b001) && (f7 != F7_ZERO)) ||
                            ((i[14:12] == 3'b101) && (f7 != F7_ZERO) && (f7 != F7_ALT));
            end
            OPC_OP: begin
                b.alu_op  = alu_from_funct3(i[14:12], f7 == F7_ALT);
                b.illegal = ((f7 != F7_ZERO) && (f7 != F7_ALT)) ||
                            ((f7 == F7_ALT) && (i[14:12] != 3'b000) && (i[14:12] != 3'b101));
            end
            default: b.illegal = 1'b1;
        endcase
        if (b.illegal) begin
            b.reg_write = 1'b0;
            b.alu_op    = ALU_ADD;
            b.is_imm    = 1'b0;
        end
        if (b.rd == 5'd0) begin
            b.reg_write = 1'b0;
        end
        return b;
    endfunction

    bundle_t main_q, skid_q, in_dec;
    logic    main_valid, skid_valid;
    logic    in_fire, out_fire;

    always_comb begin
        in_dec = decode(bus.in_inst, bus.in_pc);
    end

    assign in_fire  = bus.in_valid & ~skid_valid;
    assign out_fire = main_valid & bus.out_ready;

    // Skid only fills while main is stalled, and only empties into main, so order is preserved
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid    <= 1'b0;
            skid_valid    <= 1'b0;
            main_q        <= '0;
            skid_q        <= '0;
            decoded_count <= '0;
        end else begin
            if (out_fire) begin
                decoded_count <= decoded_count + 32'd1;
            end
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!main_valid || bus.out_ready) begin
                if (skid_valid) begin
                    main_q     <= skid_q;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (in_fire) begin
                    main_q     <= in_dec;
                    main_valid <= 1'b1;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (in_fire) begin
                skid_q     <= in_dec;
                skid_valid <= 1'b1;
            end
        end
    end

    assign bus.in_ready      = ~skid_valid;
    assign bus.out_valid     = main_valid;
    assign bus.out_pc        = main_q.pc;
    assign bus.out_opcode    = main_q.opcode;
    assign bus.out_rd        = main_q.rd;
    assign bus.out_rs1       = main_q.rs1;
    assign bus.out_rs2       = main_q.rs2;
    assign bus.out_funct3    = main_q.funct3;
    assign bus.out_imm       = main_q.imm;
    assign bus.out_alu_op    = main_q.alu_op;
    assign bus.out_is_imm    = main_q.is_imm;
    assign bus.out_reg_write = main_q.reg_write;
    assign bus.out_illegal   = main_q.illegal;
endmodule

// File: tb/tb_rv32i_inst_decoder.sv
// tb/tb_rv32i_inst_decoder.sv - scoreboard bench for the RV32I decode stage
module tb_rv32i_inst_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] decoded_count;

    rv32i_inst_decoder_if bus();

    rv32i_inst_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .bus           (bus),
        .decoded_count (decoded_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        is_imm;
        logic        reg_write;
        logic        illegal;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] vin[13];
    exp_t        vexp[13];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [31:0] imm, input logic [3:0] alu, input logic is_imm,
                                input logic rw, input logic ill);
        exp_t e;
        e.pc = pc; e.opcode = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.funct3 = f3;
        e.imm = imm; e.alu_op = alu; e.is_imm = is_imm; e.reg_write = rw; e.illegal = ill;
        return e;
    endfunction

    function automatic exp_t with_pc(input exp_t e, input logic [31:0] pc);
        exp_t r;
        r = e;
        r.pc = pc;
        return r;
    endfunction

    // Monitor: a bundle presented with out_ready high is consumed at the next rising edge
    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            act.pc = bus.out_pc; act.opcode = bus.out_opcode; act.rd = bus.out_rd;
            act.rs1 = bus.out_rs1; act.rs2 = bus.out_rs2; act.funct3 = bus.out_funct3;
            act.imm = bus.out_imm; act.alu_op = bus.out_alu_op; act.is_imm = bus.out_is_imm;
            act.reg_write = bus.out_reg_write; act.illegal = bus.out_illegal;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_bundle actual=%h required=none", act);
            end else begin
                e = exp_q.pop_front();
                chk("bundle", act, e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send(input logic [31:0] inst, input exp_t e);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = e.pc;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=accept pc=%h", e.pc);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {bus.out_valid, bus.out_pc, bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2,
                   bus.out_funct3, bus.out_imm, bus.out_alu_op, bus.out_is_imm, bus.out_reg_write,
                   bus.out_illegal, decoded_count}, '0);
    endtask

    initial begin
        vin[0]  = 32'h00500193; vexp[0]  = mk(32'h100, 7'h13, 5'd3,  5'd0,  5'd5,  3'd0, 32'h5,        4'd0,  1, 1, 0);
        vin[1]  = 32'h00200213; vexp[1]  = mk(32'h104, 7'h13, 5'd4,  5'd0,  5'd2,  3'd0, 32'h2,        4'd0,  1, 1, 0);
        vin[2]  = 32'h004182B3; vexp[2]  = mk(32'h108, 7'h33, 5'd5,  5'd3,  5'd4,  3'd0, 32'h0,        4'd0,  0, 1, 0);
        vin[3]  = 32'h404182B3; vexp[3]  = mk(32'h10C, 7'h33, 5'd5,  5'd3,  5'd4,  3'd0, 32'h0,        4'd1,  0, 1, 0);
        vin[4]  = 32'hFFF00093; vexp[4]  = mk(32'h110, 7'h13, 5'd1,  5'd0,  5'd31, 3'd0, 32'hFFFFFFFF, 4'd0,  1, 1, 0);
        vin[5]  = 32'h12345137; vexp[5]  = mk(32'h114, 7'h37, 5'd2,  5'd8,  5'd3,  3'd5, 32'h12345000, 4'd10, 1, 1, 0);
        vin[6]  = 32'hFFFFFFFF; vexp[6]  = mk(32'h118, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 32'h0,        4'd0,  0, 0, 1);
        vin[7]  = 32'h02418233; vexp[7]  = mk(32'h11C, 7'h33, 5'd4,  5'd3,  5'd4,  3'd0, 32'h0,        4'd0,  0, 0, 1);
        vin[8]  = 32'h00000013; vexp[8]  = mk(32'h120, 7'h13, 5'd0,  5'd0,  5'd0,  3'd0, 32'h0,        4'd0,  1, 0, 0);
        vin[9]  = 32'h0020A423; vexp[9]  = mk(32'h124, 7'h23, 5'd8,  5'd1,  5'd2,  3'd2, 32'h8,        4'd0,  1, 0, 0);
        vin[10] = 32'hFE208EE3; vexp[10] = mk(32'h128, 7'h63, 5'd29, 5'd1,  5'd2,  3'd0, 32'hFFFFFFFC, 4'd1,  0, 0, 0);
        vin[11] = 32'h40009093; vexp[11] = mk(32'h12C, 7'h13, 5'd1,  5'd1,  5'd0,  3'd1, 32'h400,      4'd0,  0, 0, 1);
        vin[12] = 32'h4030D093; vexp[12] = mk(32'h130, 7'h13, 5'd1,  5'd1,  5'd3,  3'd5, 32'h403,      4'd7,  1, 1, 0);

        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_outputs");
        chk("reset_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        for (int k = 0; k < 3; k++) send(vin[k], vexp[k]);
        repeat (3) @(negedge clk);
        chk("count_after_stream", decoded_count, 32'd3);
        chk("stream_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;

        for (int k = 3; k < 13; k++) send(vin[k], vexp[k]);
        repeat (3) @(negedge clk);
        chk("count_after_vectors", decoded_count, 32'd13);
        chk("vectors_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Stall: A held in main, B in skid, C waits for release
        bus.out_ready = 1'b0;
        send(vin[0], with_pc(vexp[0], 32'h200));
        @(negedge clk);
        chk("latency_out_valid", bus.out_valid, 1'b1);
        chk("latency_out_pc", bus.out_pc, 32'h200);
        @(posedge clk);
        #1;
        send(vin[1], with_pc(vexp[1], 32'h204));
        fork
            send(vin[2], with_pc(vexp[2], 32'h208));
            begin
                @(negedge clk);
                chk("stall_in_ready_low", bus.in_ready, 1'b0);
                chk("stall_hold_pc", bus.out_pc, 32'h200);
                chk("stall_hold_valid", bus.out_valid, 1'b1);
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
                @(negedge clk);
                chk("release_in_ready_still_low", bus.in_ready, 1'b0);
                chk("release_pc_still_a", bus.out_pc, 32'h200);
            end
        join
        repeat (3) @(negedge clk);
        chk("count_after_stall", decoded_count, 32'd16);
        chk("stall_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Flush with main and skid both full
        bus.out_ready = 1'b0;
        send(vin[3], with_pc(vexp[3], 32'h300));
        send(vin[4], with_pc(vexp[4], 32'h304));
        @(negedge clk);
        chk("pre_flush_in_ready", bus.in_ready, 1'b0);
        chk("pre_flush_out_valid", bus.out_valid, 1'b1);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_out_valid", bus.out_valid, 1'b0);
        chk("flush_in_ready", bus.in_ready, 1'b1);
        chk("flush_count_kept", decoded_count, 32'd16);
        @(posedge clk);
        #1;

        // Flush with an input presented in the same cycle: the input is dropped
        send(vin[5], with_pc(vexp[5], 32'h310));
        bus.in_valid = 1'b1;
        bus.in_inst  = vin[6];
        bus.in_pc    = 32'h314;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_ignores_input", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Reset mid-stream with both registers full
        send(vin[7], with_pc(vexp[7], 32'h400));
        send(vin[8], with_pc(vexp[8], 32'h404));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("midstream_reset_outputs");
        chk("midstream_reset_in_ready", bus.in_ready, 1'b1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(vin[0], with_pc(vexp[0], 32'h500));
        repeat (3) @(negedge clk);
        chk("count_after_reset", decoded_count, 32'd1);
        chk("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
